// File: rtl/mac_acc_group_if.sv
// Bus bundle for mac_acc_group: beat inputs from the producer, window
// results back to it. The master drives beats; the accumulator is the slave.
interface mac_acc_group_if #(
  parameter int N_KERNEL = 4,
  parameter int B_PIXEL  = 16,
  parameter int B_ACC    = 40,
  parameter int B_CNT    = 16
);
  logic                         clk_en;
  logic                         in_valid;
  logic                         in_first;
  logic                         in_last;
  logic                         relu;
  logic [B_PIXEL*N_KERNEL-1:0]  wei;
  logic [B_PIXEL-1:0]           ftm;

  logic                         out_valid;
  logic [B_ACC*N_KERNEL-1:0]    out_acc;
  logic [B_PIXEL*N_KERNEL-1:0]  out_q;
  logic [N_KERNEL-1:0]          out_sat;
  logic [N_KERNEL-1:0]          out_ovf;
  logic [B_CNT-1:0]             out_cnt;

  modport master (
    output clk_en, in_valid, in_first, in_last, relu, wei, ftm,
    input  out_valid, out_acc, out_q, out_sat, out_ovf, out_cnt
  );

  modport slave (
    input  clk_en, in_valid, in_first, in_last, relu, wei, ftm,
    output out_valid, out_acc, out_q, out_sat, out_ovf, out_cnt
  );
endinterface

// File: rtl/mac_acc_group.sv
// N_KERNEL parallel multiply-accumulate channels sharing one feature pixel:
// 4-stage pipeline (register, multiply, saturating accumulate, quantize).
module mac_acc_group #(
  parameter int N_KERNEL = 4,
  parameter int B_PIXEL  = 16,
  parameter int B_ACC    = 40,
  parameter int SHIFT    = 0,
  parameter int B_CNT    = 16
) (
  input  logic           clk,
  input  logic           rstn,
  mac_acc_group_if.slave bus
);
  localparam int B_PROD = 2 * B_PIXEL;
  localparam int B_SUM  = B_ACC + 1;
  localparam int B_HI   = B_SUM - B_PIXEL + 1;

  typedef logic signed [B_PIXEL-1:0] pix_t;
  typedef logic signed [B_PROD-1:0]  prod_t;
  typedef logic signed [B_ACC-1:0]   acc_t;
  typedef logic signed [B_SUM-1:0]   sum_t;

  localparam acc_t ACC_MAX = {1'b0, {(B_ACC-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(B_ACC-1){1'b0}}};
  localparam pix_t PIX_MAX = {1'b0, {(B_PIXEL-1){1'b1}}};
  localparam pix_t PIX_MIN = {1'b1, {(B_PIXEL-1){1'b0}}};
  // Half-LSB rounding term; collapses to zero when SHIFT is 0.
  localparam sum_t RND     = (sum_t'(1) <<< SHIFT) >>> 1;

  // S1: registered inputs
  logic                        v1_q, v1_d, f1_q, f1_d, l1_q, l1_d, r1_q, r1_d;
  logic [B_PIXEL*N_KERNEL-1:0] wei1_q, wei1_d;
  pix_t                        ftm1_q, ftm1_d;

  // S2: products
  logic                        v2_q, v2_d, f2_q, f2_d, l2_q, l2_d, r2_q, r2_d;
  prod_t                       prod2_q [N_KERNEL];
  prod_t                       prod2_d [N_KERNEL];
  prod_t                       mul_a, mul_b;

  // S3: accumulators
  logic                        done3_q, done3_d, relu3_q, relu3_d;
  acc_t                        acc_q [N_KERNEL];
  acc_t                        acc_d [N_KERNEL];
  logic [B_CNT-1:0]            cnt_q, cnt_d;
  logic [N_KERNEL-1:0]         ovf_q, ovf_d;
  sum_t                        sum;

  // S4: quantized outputs
  logic                        ov_q, ov_d;
  logic [B_ACC*N_KERNEL-1:0]   oacc_q, oacc_d;
  logic [B_PIXEL*N_KERNEL-1:0] oq_q, oq_d;
  logic [N_KERNEL-1:0]         osat_q, osat_d, oovf_q, oovf_d;
  logic [B_CNT-1:0]            ocnt_q, ocnt_d;
  sum_t                        rsum, shifted;
  logic [B_HI-1:0]             hi;
  pix_t                        q;

  always_comb begin
    v1_d   = bus.in_valid;
    f1_d   = bus.in_valid & bus.in_first;
    l1_d   = bus.in_valid & bus.in_last;
    r1_d   = bus.relu;
    wei1_d = bus.wei;
    ftm1_d = bus.ftm;
  end

  always_comb begin
    v2_d  = v1_q;
    f2_d  = f1_q;
    l2_d  = l1_q;
    r2_d  = r1_q;
    mul_a = '0;
    mul_b = prod_t'(ftm1_q);
    for (int unsigned j = 0; j < N_KERNEL; j++) begin
      mul_a      = prod_t'(pix_t'(wei1_q[j*B_PIXEL +: B_PIXEL]));
      prod2_d[j] = mul_a * mul_b;
    end
  end

  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    sum     = '0;
    done3_d = v2_q & l2_q;
    relu3_d = r2_q;
    if (v2_q) begin
      if (f2_q) begin
        cnt_d = B_CNT'(1);
        ovf_d = '0;
        for (int unsigned j = 0; j < N_KERNEL; j++) begin
          acc_d[j] = acc_t'(prod2_q[j]);
        end
      end else begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + B_CNT'(1);
        end
        // One guard bit: sign mismatch between the top two bits means overflow.
        for (int unsigned j = 0; j < N_KERNEL; j++) begin
          sum = sum_t'(acc_q[j]) + sum_t'(prod2_q[j]);
          if (sum[B_SUM-1] != sum[B_SUM-2]) begin
            acc_d[j] = sum[B_SUM-1] ? ACC_MIN : ACC_MAX;
            ovf_d[j] = 1'b1;
          end else begin
            acc_d[j] = sum[B_ACC-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    ov_d    = done3_q;
    oacc_d  = oacc_q;
    oq_d    = oq_q;
    osat_d  = osat_q;
    oovf_d  = oovf_q;
    ocnt_d  = ocnt_q;
    rsum    = '0;
    shifted = '0;
    hi      = '0;
    q       = '0;
    if (done3_q) begin
      ocnt_d = cnt_q;
      oovf_d = ovf_q;
      for (int unsigned j = 0; j < N_KERNEL; j++) begin
        rsum    = sum_t'(acc_q[j]) + RND;
        shifted = rsum >>> SHIFT;
        hi      = shifted[B_SUM-1:B_PIXEL-1];
        if ((&hi) || !(|hi)) begin
          q         = shifted[B_PIXEL-1:0];
          osat_d[j] = 1'b0;
        end else begin
          q         = shifted[B_SUM-1] ? PIX_MIN : PIX_MAX;
          osat_d[j] = 1'b1;
        end
        if (relu3_q && q[B_PIXEL-1]) begin
          q = '0;
        end
        oacc_d[j*B_ACC +: B_ACC]     = acc_q[j];
        oq_d[j*B_PIXEL +: B_PIXEL]   = q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q    <= 1'b0;
      f1_q    <= 1'b0;
      l1_q    <= 1'b0;
      r1_q    <= 1'b0;
      wei1_q  <= '0;
      ftm1_q  <= '0;
      v2_q    <= 1'b0;
      f2_q    <= 1'b0;
      l2_q    <= 1'b0;
      r2_q    <= 1'b0;
      prod2_q <= '{default: '0};
      done3_q <= 1'b0;
      relu3_q <= 1'b0;
      acc_q   <= '{default: '0};
      cnt_q   <= '0;
      ovf_q   <= '0;
      ov_q    <= 1'b0;
      oacc_q  <= '0;
      oq_q    <= '0;
      osat_q  <= '0;
      oovf_q  <= '0;
      ocnt_q  <= '0;
    end else if (bus.clk_en) begin
      v1_q    <= v1_d;
      f1_q    <= f1_d;
      l1_q    <= l1_d;
      r1_q    <= r1_d;
      wei1_q  <= wei1_d;
      ftm1_q  <= ftm1_d;
      v2_q    <= v2_d;
      f2_q    <= f2_d;
      l2_q    <= l2_d;
      r2_q    <= r2_d;
      prod2_q <= prod2_d;
      done3_q <= done3_d;
      relu3_q <= relu3_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
      oacc_q  <= oacc_d;
      oq_q    <= oq_d;
      osat_q  <= osat_d;
      oovf_q  <= oovf_d;
      ocnt_q  <= ocnt_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_acc   = oacc_q;
  assign bus.out_q     = oq_q;
  assign bus.out_sat   = osat_q;
  assign bus.out_ovf   = oovf_q;
  assign bus.out_cnt   = ocnt_q;
endmodule

// File: tb/tb_mac_acc_group.sv
// Two instances (wide accumulator/no shift, narrow accumulator/shift 2/short
// counter) share one beat stream and are checked against a window-level model.
module tb_mac_acc_group;
  localparam int NK  = 2;
  localparam int BP  = 16;
  localparam int BA0 = 40;
  localparam int SH0 = 0;
  localparam int BC0 = 16;
  localparam int BA1 = 33;
  localparam int SH1 = 2;
  localparam int BC1 = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  mac_acc_group_if #(.N_KERNEL(NK), .B_PIXEL(BP), .B_ACC(BA0), .B_CNT(BC0)) bus0 ();
  mac_acc_group_if #(.N_KERNEL(NK), .B_PIXEL(BP), .B_ACC(BA1), .B_CNT(BC1)) bus1 ();

  assign bus1.clk_en   = bus0.clk_en;
  assign bus1.in_valid = bus0.in_valid;
  assign bus1.in_first = bus0.in_first;
  assign bus1.in_last  = bus0.in_last;
  assign bus1.relu     = bus0.relu;
  assign bus1.wei      = bus0.wei;
  assign bus1.ftm      = bus0.ftm;

  mac_acc_group #(.N_KERNEL(NK), .B_PIXEL(BP), .B_ACC(BA0), .SHIFT(SH0), .B_CNT(BC0))
    dut0 (.clk(clk), .rstn(rstn), .bus(bus0));
  mac_acc_group #(.N_KERNEL(NK), .B_PIXEL(BP), .B_ACC(BA1), .SHIFT(SH1), .B_CNT(BC1))
    dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

  typedef struct {
    longint a0, a1, q0, q1;
    bit     s0, s1, o0, o1;
    int     cnt;
    int     due;
  } exp_t;

  exp_t   eq0[$];
  exp_t   eq1[$];
  longint macc[2][2];
  int     mcnt[2];
  bit     movf[2][2];
  int     n_vec  = 0;
  int     n_err  = 0;
  int     edge_n = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int p_ba(input int d); return (d == 0) ? BA0 : BA1; endfunction
  function automatic int p_sh(input int d); return (d == 0) ? SH0 : SH1; endfunction
  function automatic int p_bc(input int d); return (d == 0) ? BC0 : BC1; endfunction

  function automatic longint sx(input logic [79:0] v, input int lsb, input int w);
    logic [79:0] t;
    longint      r;
    t = v >> lsb;
    r = longint'(t[63:0]);
    r = (r <<< (64 - w)) >>> (64 - w);
    return r;
  endfunction

  function automatic logic [31:0] wv(input int k1, input int k0);
    logic [15:0] a, b;
    a = k1[15:0];
    b = k0[15:0];
    return {a, b};
  endfunction

  function automatic logic [15:0] rpix();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic model_beat(input bit v, input bit f, input bit l, input bit rl,
                            input logic [31:0] w, input logic [15:0] x);
    longint p, s, lim, r;
    longint qv[2], av[2];
    bit     sv[2], ov[2];
    exp_t   e;
    if (!v) return;
    for (int d = 0; d < 2; d++) begin
      lim = longint'(1) <<< (p_ba(d) - 1);
      for (int j = 0; j < 2; j++) begin
        p = longint'($signed(w[j*16 +: 16])) * longint'($signed(x));
        if (f) begin
          macc[d][j] = p;
          movf[d][j] = 1'b0;
        end else begin
          s = macc[d][j] + p;
          if (s > lim - 1) begin
            s = lim - 1;
            movf[d][j] = 1'b1;
          end else if (s < -lim) begin
            s = -lim;
            movf[d][j] = 1'b1;
          end
          macc[d][j] = s;
        end
        r = macc[d][j] + ((p_sh(d) > 0) ? (longint'(1) <<< (p_sh(d) - 1)) : 0);
        r = r >>> p_sh(d);
        sv[j] = 1'b0;
        if (r > 32767) begin
          r = 32767;
          sv[j] = 1'b1;
        end else if (r < -32768) begin
          r = -32768;
          sv[j] = 1'b1;
        end
        if (rl && r < 0) r = 0;
        qv[j] = r;
        av[j] = macc[d][j];
        ov[j] = movf[d][j];
      end
      if (f) mcnt[d] = 1;
      else if (mcnt[d] < (1 << p_bc(d)) - 1) mcnt[d]++;
      if (l) begin
        e.a0 = av[0]; e.a1 = av[1]; e.q0 = qv[0]; e.q1 = qv[1];
        e.s0 = sv[0]; e.s1 = sv[1]; e.o0 = ov[0]; e.o1 = ov[1];
        e.cnt = mcnt[d];
        e.due = edge_n + 3;
        if (d == 0) eq0.push_back(e);
        else        eq1.push_back(e);
      end
    end
  endtask

  task automatic mon(input int d, input logic ov, input logic [79:0] av, input logic [31:0] qv,
                     input logic [1:0] sv, input logic [1:0] fv, input int cv);
    exp_t e;
    bit   is_due;
    int   ba;
    ba = p_ba(d);
    if (d == 0) is_due = (eq0.size() > 0) && (eq0[0].due == edge_n);
    else        is_due = (eq1.size() > 0) && (eq1[0].due == edge_n);
    chk($sformatf("d%0d out_valid @edge %0d", d, edge_n), longint'(ov), longint'(is_due));
    if (is_due) begin
      if (d == 0) e = eq0.pop_front();
      else        e = eq1.pop_front();
      if (ov === 1'b1) begin
        chk($sformatf("d%0d out_acc0", d), sx(av, 0, ba),  e.a0);
        chk($sformatf("d%0d out_acc1", d), sx(av, ba, ba), e.a1);
        chk($sformatf("d%0d out_q0", d),   sx({48'd0, qv}, 0, 16),  e.q0);
        chk($sformatf("d%0d out_q1", d),   sx({48'd0, qv}, 16, 16), e.q1);
        chk($sformatf("d%0d out_sat0", d), longint'(sv[0]), longint'(e.s0));
        chk($sformatf("d%0d out_sat1", d), longint'(sv[1]), longint'(e.s1));
        chk($sformatf("d%0d out_ovf0", d), longint'(fv[0]), longint'(e.o0));
        chk($sformatf("d%0d out_ovf1", d), longint'(fv[1]), longint'(e.o1));
        chk($sformatf("d%0d out_cnt", d),  longint'(cv),    longint'(e.cnt));
      end
    end
  endtask

  task automatic step(input bit v, input bit f, input bit l, input bit rl, input bit en,
                      input logic [31:0] w, input logic [15:0] x);
    bus0.in_valid = v;
    bus0.in_first = f;
    bus0.in_last  = l;
    bus0.relu     = rl;
    bus0.clk_en   = en;
    bus0.wei      = w;
    bus0.ftm      = x;
    @(posedge clk);
    #1;
    if (en) begin
      edge_n++;
      model_beat(v, f, l, rl, w, x);
      mon(0, bus0.out_valid, {bus0.out_acc}, bus0.out_q, bus0.out_sat, bus0.out_ovf,
          int'(bus0.out_cnt));
      mon(1, bus1.out_valid, {14'd0, bus1.out_acc}, bus1.out_q, bus1.out_sat, bus1.out_ovf,
          int'(bus1.out_cnt));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " d0 out_valid"}, longint'(bus0.out_valid), 0);
    chk({tag, " d0 out_acc"},   longint'(|bus0.out_acc),  0);
    chk({tag, " d0 out_q"},     longint'(|bus0.out_q),    0);
    chk({tag, " d0 out_sat"},   longint'(bus0.out_sat),   0);
    chk({tag, " d0 out_ovf"},   longint'(bus0.out_ovf),   0);
    chk({tag, " d0 out_cnt"},   longint'(bus0.out_cnt),   0);
    chk({tag, " d1 out_valid"}, longint'(bus1.out_valid), 0);
    chk({tag, " d1 out_acc"},   longint'(|bus1.out_acc),  0);
    chk({tag, " d1 out_q"},     longint'(|bus1.out_q),    0);
    chk({tag, " d1 out_cnt"},   longint'(bus1.out_cnt),   0);
  endtask

  task automatic pulse_reset(input string tag);
    bus0.in_valid = 1'b0;
    bus0.in_first = 1'b0;
    bus0.in_last  = 1'b0;
    #2 rstn = 1'b0;
    #1 check_zero(tag);
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0;
      for (int j = 0; j < 2; j++) begin
        macc[d][j] = 0;
        movf[d][j] = 1'b0;
      end
    end
    eq0.delete();
    eq1.delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  initial begin
    bus0.clk_en   = 1'b1;
    bus0.in_valid = 1'b0;
    bus0.in_first = 1'b0;
    bus0.in_last  = 1'b0;
    bus0.relu     = 1'b0;
    bus0.wei      = '0;
    bus0.ftm      = '0;
    @(posedge clk);
    #1;
    pulse_reset("reset");
    idle(2);

    // three-beat window, then the same with relu on the last beat
    for (int r = 0; r < 2; r++) begin
      step(1, 1, 0, 0,        1, wv(-4, 3), 16'(2));
      step(1, 0, 0, 0,        1, wv(-4, 3), 16'(2));
      step(1, 0, 1, r[0],     1, wv(-4, 3), 16'(2));
      idle(5);
    end

    // two stalled cycles mid-window; beats offered while stalled are ignored
    step(1, 1, 0, 0, 1, wv(-4, 3), 16'(2));
    step(1, 1, 1, 0, 0, wv(77, 77), 16'(9));
    step(1, 0, 1, 0, 0, wv(77, 77), 16'(9));
    step(1, 0, 0, 0, 1, wv(-4, 3), 16'(2));
    step(1, 0, 1, 0, 1, wv(-4, 3), 16'(2));
    idle(5);

    // single-term extremes and rounding at shift 2
    step(1, 1, 1, 0, 1, wv(5, -32768), 16'(-32768));
    step(1, 1, 1, 0, 1, wv(-3, 3), 16'(2));
    step(1, 1, 1, 1, 1, wv(-3, 3), 16'(2));
    idle(5);

    // accumulator saturation, then a non-first window keeps the sticky flag
    for (int i = 0; i < 5; i++) step(1, i == 0, i == 4, 0, 1, wv(32767, -32768), 16'(-32768));
    step(1, 0, 1, 0, 1, wv(1, 1), 16'(1));
    idle(5);

    // idle beats mid-window, then a restart that discards a partial sum
    step(1, 1, 0, 0, 1, wv(100, -7), 16'(11));
    step(0, 0, 1, 0, 1, wv(9, 9), 16'(9));
    step(0, 1, 0, 0, 1, wv(9, 9), 16'(9));
    step(1, 0, 1, 0, 1, wv(-50, 13), 16'(-3));
    step(1, 1, 0, 0, 1, wv(1000, 2000), 16'(300));
    step(1, 0, 0, 0, 1, wv(1000, 2000), 16'(300));
    step(1, 1, 0, 0, 1, wv(-2, 5), 16'(7));
    step(1, 0, 1, 0, 1, wv(-2, 5), 16'(7));
    idle(5);

    // back-to-back two-beat windows, then a long window past the short counter
    for (int i = 0; i < 8; i++) step(1, (i % 2) == 0, (i % 2) == 1, 0, 1, $urandom(), rpix());
    for (int i = 0; i < 20; i++) step(1, i == 0, i == 19, 0, 1, wv(3, -2), 16'(5));
    idle(5);

    // reset with a window open, then accumulate from zero without a first beat
    step(1, 1, 0, 0, 1, wv(40, 41), 16'(42));
    step(1, 0, 0, 0, 1, wv(40, 41), 16'(42));
    pulse_reset("mid-window reset");
    step(1, 0, 0, 0, 1, wv(-6, 6), 16'(3));
    step(1, 0, 1, 0, 1, wv(-6, 6), 16'(3));
    step(1, 1, 1, 0, 1, wv(8, -8), 16'(4));
    idle(5);

    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0,
           {rpix(), rpix()}, rpix());
    end
    idle(6);
    chk("drain d0", longint'(eq0.size()), 0);
    chk("drain d1", longint'(eq1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mac_acc_group.md
MAC_ACC_GROUP -- requirements
Module: mac_acc_group

Interface
REQ-001 SHALL have parameter N_KERNEL, default 4: number of parallel kernel channels.
REQ-002 SHALL have parameter B_PIXEL, default 16: signed width of wei and ftm elements and of quantized outputs.
REQ-003 SHALL have parameter B_ACC, default 40 (range 2*B_PIXEL+1..48): signed accumulator width.
REQ-004 SHALL have parameter SHIFT, default 0 (range 0..B_ACC-B_PIXEL): right shift applied before quantization.
REQ-005 SHALL have parameter B_CNT, default 16: width of the term counter.
REQ-006 SHALL have one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-007 rstn  in  1  asynchronous active-low reset.
REQ-008 clk_en  in  1  global stall; low freezes every register.
REQ-009 in_valid  in  1  input beat valid.
REQ-010 in_first  in  1  first beat of window; qualified by in_valid.
REQ-011 in_last  in  1  last beat of window; qualified by in_valid.
REQ-012 relu  in  1  clamp negative quantized results to 0; sampled with the in_last beat.
REQ-013 wei  in  B_PIXEL*N_KERNEL  signed weights, channel j at bits [j*B_PIXEL +: B_PIXEL].
REQ-014 ftm  in  B_PIXEL  signed feature pixel, broadcast to all channels.
REQ-015 out_valid  out  1  one clk_en-qualified beat per completed window.
REQ-016 out_acc  out  B_ACC*N_KERNEL  raw signed window sums.
REQ-017 out_q  out  B_PIXEL*N_KERNEL  rounded, shifted, saturated, optional ReLU results.
REQ-018 out_sat  out  N_KERNEL  per-channel flag: quantization saturated.
REQ-019 out_ovf  out  N_KERNEL  per-channel flag: accumulator saturated during the window.
REQ-020 out_cnt  out  B_CNT  number of beats in the window.

Function
REQ-021 SHALL advance all pipeline registers only on rising clk edges with clk_en=1; with clk_en=0, all state and outputs hold.
REQ-022 SHALL use pipeline S1 (register inputs and controls), S2 (register 2*B_PIXEL signed product wei_j*ftm), S3 (accumulate), S4 (quantize and register outputs); latency from in_last beat to out_valid = 4 enabled edges.
REQ-023 S3 on a valid beat with first=1: acc_j <= sext(product_j), cnt <= 1, ovf_j <= 0; with first=0: acc_j <= acc_j + product_j, cnt <= cnt+1.
REQ-024 Accumulation SHALL saturate at the B_ACC signed limits and set ovf_j sticky until the next first beat.
REQ-025 cnt SHALL saturate at 2^B_CNT-1.
REQ-026 A valid beat without in_first after a completed window or after reset SHALL accumulate onto the current acc (0 after reset).
REQ-027 in_first during an open window SHALL discard the partial sum and emit no output for it.
REQ-028 in_first and in_last on the same beat SHALL form a single-term window.
REQ-029 Beats with in_valid=0 SHALL leave acc and cnt unchanged, including mid-window.
REQ-030 Quantization: q = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up; no rounding term when SHIFT=0), saturated to the B_PIXEL signed range; out_sat_j=1 if clipped; if relu=1 and q<0 then q=0 (out_sat unaffected).
REQ-031 On the window-end beat S4 SHALL load out_acc, out_q, out_sat, out_ovf, out_cnt and assert out_valid for one enabled cycle; the data outputs hold until the next window end.
REQ-032 Back-to-back windows (last followed by first on the next beat) SHALL run at full rate without bubbles.

Reset
REQ-033 rstn=0 SHALL immediately clear all registers: out_valid=0, out_acc=0, out_q=0, out_sat=0, out_ovf=0, out_cnt=0, internal acc=0, cnt=0, and all in-flight pipeline valids; a window open at reset is discarded.

Verification
REQ-034 N_KERNEL=2, SHIFT=0; 3-beat window ftm=2, wei={k0=3,k1=-4} -> 4 enabled edges after last: out_acc={6*3=18,-24}, out_q={18,-24}, out_cnt=3, flags 0.
REQ-035 Single beat first&last, ftm=-32768, wei k0=-32768 -> out_acc k0=1073741824, out_q k0=32767, out_sat[0]=1.
REQ-036 Same as REQ-034 with relu=1 -> out_q k1=0, out_acc k1=-24, out_sat[1]=0.
REQ-037 SHIFT=2, window sums 6 and -6 -> out_q 2 and -1.
REQ-038 clk_en held low 2 cycles mid-window -> out_valid 2 cycles later, values identical to REQ-034.
REQ-039 rstn pulsed low mid-window -> all outputs 0 at once; next beats without first accumulate from 0; new first/last windows are correct.
